// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, default payload width and the
// parity-type encoding used by both the transmit and receive sides.
package uart_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/uart_tx_parity_calc.sv
// Parity bit for the latched transmit payload: XOR of the data for even
// parity, XNOR for odd parity.
module uart_tx_parity_calc
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_par_typ,
  output logic                  o_parity
);

  function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] data,
                                       input logic                  typ);
    logic even_bit;
    even_bit = ^data;
    return (typ == PAR_ODD) ? ~even_bit : even_bit;
  endfunction

  assign o_parity = calc_parity(i_data, i_par_typ);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one serial bit per clk cycle, optional parity, back-to-back
// frames accepted during the stop bit. TX_OUT and busy come straight from flops.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  busy
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  tx_state_e             r_state;
  tx_state_e             w_state_next;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_next;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic                  w_accept;
  logic                  w_parity;
  logic                  w_tx_next;
  logic                  w_busy_next;

  uart_tx_parity_calc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_parity_calc (
    .i_data   (r_data),
    .i_par_typ(r_par_typ),
    .o_parity (w_parity)
  );

  // Next state, bit counter and acceptance decision
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = {CNT_W{1'b0}};
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE, ST_STOP: begin
        if (DATA_VALID) begin
          w_accept     = 1'b1;
          w_state_next = ST_START;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_START: begin
        w_state_next = ST_DATA;
      end
      ST_DATA: begin
        if (r_cnt == CNT_LAST) begin
          w_state_next = r_par_en ? ST_PARITY : ST_STOP;
        end else begin
          w_state_next = ST_DATA;
          w_cnt_next   = r_cnt + CNT_W'(1);
        end
      end
      ST_PARITY: begin
        w_state_next = ST_STOP;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Line value for the coming cycle, chosen from the next state so the output flop alone drives TX_OUT
  always_comb begin
    w_tx_next   = 1'b1;
    w_busy_next = (w_state_next != ST_IDLE);
    case (w_state_next)
      ST_IDLE:   w_tx_next = 1'b1;
      ST_START:  w_tx_next = 1'b0;
      ST_DATA:   w_tx_next = r_data[w_cnt_next];
      ST_PARITY: w_tx_next = w_parity;
      ST_STOP:   w_tx_next = 1'b1;
      default:   w_tx_next = 1'b1;
    endcase
  end

  // State, counter and registered serial outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= {CNT_W{1'b0}};
      TX_OUT  <= 1'b1;
      busy    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      TX_OUT  <= w_tx_next;
      busy    <= w_busy_next;
    end
  end

  // Frame configuration captured only on acceptance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data    <= {DATA_WIDTH{1'b0}};
      r_par_en  <= 1'b0;
      r_par_typ <= 1'b0;
    end else if (w_accept) begin
      r_data    <= P_DATA;
      r_par_en  <= PAR_EN;
      r_par_typ <= PAR_TYP;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: expected {TX_OUT, busy} per cycle is queued when
// a frame is requested and compared one entry per clock.
module tb_uart_tx;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] P_DATA = 8'h00;
  logic          DATA_VALID = 1'b0;
  logic          PAR_EN = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic          TX_OUT;
  logic          busy;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  logic [1:0] exp_q[$];

  uart_tx #(.DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .P_DATA    (P_DATA),
    .DATA_VALID(DATA_VALID),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .TX_OUT    (TX_OUT),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed tx,busy=%b required %b", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [DW-1:0] d, input logic pen, input logic pt);
    exp_q.push_back(2'b01);
    for (int i = 0; i < DW; i++) exp_q.push_back({d[i], 1'b1});
    if (pen) exp_q.push_back({(pt ? ~(^d) : (^d)), 1'b1});
    exp_q.push_back(2'b11);
  endtask

  // One clock; compare against the next queued value, or idle line when nothing is queued
  task automatic cycle(input string tag);
    logic [1:0] e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = 2'b10;
    check(tag, {TX_OUT, busy}, e);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  task automatic drive(input logic dv, input logic [DW-1:0] d, input logic pen, input logic pt);
    DATA_VALID = dv;
    P_DATA     = d;
    PAR_EN     = pen;
    PAR_TYP    = pt;
  endtask

  initial begin
    #12;
    check("reset_state", {TX_OUT, busy}, 2'b10);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run("idle_after_reset", 1);

    // Case 1: 0xA5, even parity
    drive(1'b1, 8'hA5, 1'b1, 1'b0);
    push_frame(8'hA5, 1'b1, 1'b0);
    cycle("c1_start");
    DATA_VALID = 1'b0;
    run("c1_frame", 10);
    run("c1_idle", 2);

    // Case 2: 0xA5, odd parity
    drive(1'b1, 8'hA5, 1'b1, 1'b1);
    push_frame(8'hA5, 1'b1, 1'b1);
    cycle("c2_start");
    DATA_VALID = 1'b0;
    run("c2_frame", 10);
    run("c2_idle", 2);

    // Case 3: 0x01, no parity
    drive(1'b1, 8'h01, 1'b0, 1'b0);
    push_frame(8'h01, 1'b0, 1'b0);
    cycle("c3_start");
    DATA_VALID = 1'b0;
    run("c3_frame", 9);
    run("c3_idle", 2);

    // Case 4: back-to-back, inputs change mid-frame, second frame accepted in stop bit
    drive(1'b1, 8'h3C, 1'b1, 1'b0);
    push_frame(8'h3C, 1'b1, 1'b0);
    cycle("c4_start1");
    P_DATA  = 8'hC3;
    PAR_TYP = 1'b1;
    push_frame(8'hC3, 1'b1, 1'b1);
    run("c4_frame1", 10);
    cycle("c4_start2");
    DATA_VALID = 1'b0;
    run("c4_frame2", 10);
    run("c4_idle", 2);

    // Case 5: request pulse during DATA is ignored
    drive(1'b1, 8'h00, 1'b0, 1'b0);
    push_frame(8'h00, 1'b0, 1'b0);
    cycle("c5_start");
    DATA_VALID = 1'b0;
    run("c5_data", 3);
    drive(1'b1, 8'hFF, 1'b1, 1'b1);
    cycle("c5_pulse");
    DATA_VALID = 1'b0;
    run("c5_frame", 5);
    run("c5_idle", 3);

    // Case 6: reset during data bit 4, then a fresh frame on the first edge after release
    drive(1'b1, 8'h55, 1'b0, 1'b0);
    push_frame(8'h55, 1'b0, 1'b0);
    cycle("c6_start");
    DATA_VALID = 1'b0;
    run("c6_bits", 5);
    #2;
    rst = 1'b1;
    #1;
    check("c6_rst_immediate", {TX_OUT, busy}, 2'b10);
    exp_q.delete();
    run("c6_rst_hold", 2);
    rst = 1'b0;
    drive(1'b1, 8'h0F, 1'b1, 1'b0);
    push_frame(8'h0F, 1'b1, 1'b0);
    cycle("c6_new_start");
    DATA_VALID = 1'b0;
    run("c6_new_frame", 10);
    run("c6_idle", 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
